bcd_step_ctrl: RTL

BCD_STEP_CTRL -- requirements
Module: bcd_step_ctrl

---
 rtl/bcd_step_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/bcd_step_ctrl.sv
// Two-digit BCD up/down counter stepped by push buttons, with press detection and a hold FSM.
// Define BCD_AUTO_REPEAT_EN to enable hold-to-repeat stepping; the default build steps once per press.
module bcd_step_ctrl #(
  parameter int unsigned DIGIT_MAX     = 9,
  parameter int unsigned HOLD_CYCLES   = 12500000,
  parameter int unsigned REPEAT_CYCLES = 2500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Up,
  input  logic       i_Down,
  output logic [3:0] o_Ones,
  output logic [3:0] o_Tens,
  output logic       o_Step,
  output logic       o_Wrap
);

  localparam logic [3:0] DMax = 4'(DIGIT_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StHoldUp,
    StHoldDn,
    StRepUp,
    StRepDn
  } state_e;

  state_e     state_q, state_d;
  logic       up_q, dn_q;
  logic [3:0] ones_q, tens_q;
  logic       step_q, wrap_q;

  logic       up_press, dn_press;
  logic       do_up, do_dn, do_clr;
  logic [3:0] inc_ones, inc_tens, dec_ones, dec_tens;
  logic       inc_wrap, dec_wrap;

`ifdef BCD_AUTO_REPEAT_EN
  localparam int unsigned TMax  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW    = (TMax > 1) ? $clog2(TMax) : 1;
  localparam logic [TW-1:0] HoldLast = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] RepLast  = TW'(REPEAT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;
`endif

  assign up_press = i_Up & ~up_q;
  assign dn_press = i_Down & ~dn_q;

  // Next count values for either direction; the FSM picks one.
  always_comb begin
    inc_ones = ones_q;
    inc_tens = tens_q;
    inc_wrap = 1'b0;
    if (ones_q < DMax) begin
      inc_ones = ones_q + 4'd1;
    end else if (tens_q < DMax) begin
      inc_ones = 4'd0;
      inc_tens = tens_q + 4'd1;
    end else begin
      inc_ones = 4'd0;
      inc_tens = 4'd0;
      inc_wrap = 1'b1;
    end

    dec_ones = ones_q;
    dec_tens = tens_q;
    dec_wrap = 1'b0;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_ones = DMax;
      dec_tens = tens_q - 4'd1;
    end else begin
      dec_ones = DMax;
      dec_tens = DMax;
      dec_wrap = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    do_up   = 1'b0;
    do_dn   = 1'b0;
    do_clr  = 1'b0;
`ifdef BCD_AUTO_REPEAT_EN
    timer_d = timer_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (up_press && dn_press) begin
          do_clr = 1'b1;
        end else if (up_press) begin
          do_up   = 1'b1;
          state_d = StHoldUp;
`ifdef BCD_AUTO_REPEAT_EN
          timer_d = '0;
`endif
        end else if (dn_press) begin
          do_dn   = 1'b1;
          state_d = StHoldDn;
`ifdef BCD_AUTO_REPEAT_EN
          timer_d = '0;
`endif
        end
      end
`ifdef BCD_AUTO_REPEAT_EN
      StHoldUp: begin
        if (!i_Up) begin
          state_d = StIdle;
        end else if (timer_q == HoldLast) begin
          do_up   = 1'b1;
          timer_d = '0;
          state_d = StRepUp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StHoldDn: begin
        if (!i_Down) begin
          state_d = StIdle;
        end else if (timer_q == HoldLast) begin
          do_dn   = 1'b1;
          timer_d = '0;
          state_d = StRepDn;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRepUp: begin
        if (!i_Up) begin
          state_d = StIdle;
        end else if (timer_q == RepLast) begin
          do_up   = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRepDn: begin
        if (!i_Down) begin
          state_d = StIdle;
        end else if (timer_q == RepLast) begin
          do_dn   = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`else
      StHoldUp: begin
        if (!i_Up) state_d = StIdle;
      end
      StHoldDn: begin
        if (!i_Down) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Registered levels reset high so a button held through reset needs a fresh press.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= StIdle;
      up_q    <= 1'b1;
      dn_q    <= 1'b1;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef BCD_AUTO_REPEAT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      up_q    <= i_Up;
      dn_q    <= i_Down;
      step_q  <= do_up | do_dn | do_clr;
      wrap_q  <= (do_up & inc_wrap) | (do_dn & dec_wrap);
`ifdef BCD_AUTO_REPEAT_EN
      timer_q <= timer_d;
`endif
      if (do_clr) begin
        ones_q <= 4'd0;
        tens_q <= 4'd0;
      end else if (do_up) begin
        ones_q <= inc_ones;
        tens_q <= inc_tens;
      end else if (do_dn) begin
        ones_q <= dec_ones;
        tens_q <= dec_tens;
      end
    end
  end

  assign o_Ones = ones_q;
  assign o_Tens = tens_q;
  assign o_Step = step_q;
  assign o_Wrap = wrap_q;

endmodule
